// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared BCD digit type, digit limits and modulus split helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam bcd_digit_t MIN_DIGIT     = 4'd0;

  function automatic bcd_digit_t bcd_tens(input int n);
    return bcd_digit_t'((n / 10) % 10);
  endfunction

  function automatic bcd_digit_t bcd_units(input int n);
    return bcd_digit_t'(n % 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// ============================================================================
// bcd_digit_step : one BCD digit incremented/decremented with rollover flag
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       down,
  output logic [3:0] next_digit,
  output logic       rollover
);
  import clock_pkg::*;

  always_comb begin
    next_digit = digit;
    rollover   = 1'b0;
    if (down) begin
      rollover   = (digit == MIN_DIGIT);
      next_digit = rollover ? BCD_MAX_DIGIT : digit - 4'd1;
    end else begin
      rollover   = (digit == BCD_MAX_DIGIT);
      next_digit = rollover ? MIN_DIGIT : digit + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// bcd_mod_counter : two-digit BCD modulo counter with load and cascade carry.
// Define BCD_CNT_DOWN_EN to build in down-counting and borrow generation.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_mod_counter #(
  parameter int MODULUS = 60
) (
  input  logic       cnt_clock,
  input  logic       reset,
  input  logic       cnt_en,
  input  logic       cnt_down,
  input  logic       cnt_load,
  input  logic [3:0] cnt_load_lsd,
  input  logic [3:0] cnt_load_msd,
  output logic [3:0] cnt_lsd,
  output logic [3:0] cnt_msd,
  output logic       cnt_carry,
  output logic       cnt_load_err
);
  import clock_pkg::*;

  localparam bcd_digit_t TERM_MSD = bcd_tens(MODULUS - 1);
  localparam bcd_digit_t TERM_LSD = bcd_units(MODULUS - 1);
  localparam logic [7:0] MOD_W    = 8'(MODULUS);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be in 2..100");
  end

  logic       dir_down;
  logic       at_max;
  logic       terminal;
  logic [3:0] lsd_step;
  logic [3:0] msd_step;
  logic       lsd_roll;
  logic       msd_roll_unused;
  logic [3:0] next_lsd;
  logic [3:0] next_msd;
  logic [7:0] load_value;
  logic       load_ok;

  assign at_max = (cnt_msd == TERM_MSD) && (cnt_lsd == TERM_LSD);

`ifdef BCD_CNT_DOWN_EN
  logic at_zero;
  assign dir_down = cnt_down;
  assign at_zero  = (cnt_msd == MIN_DIGIT) && (cnt_lsd == MIN_DIGIT);
  assign terminal = dir_down ? at_zero : at_max;
`else
  logic unused_cnt_down;
  assign unused_cnt_down = cnt_down;
  assign dir_down        = 1'b0;
  assign terminal        = at_max;
`endif

  bcd_digit_step u_lsd_step (
    .digit      (cnt_lsd),
    .down       (dir_down),
    .next_digit (lsd_step),
    .rollover   (lsd_roll)
  );

  bcd_digit_step u_msd_step (
    .digit      (cnt_msd),
    .down       (dir_down),
    .next_digit (msd_step),
    .rollover   (msd_roll_unused)
  );

  // The tens digit only moves when the units digit rolls; the modulus wrap
  // overrides both digits because it rarely lands on a 9->0 boundary.
  always_comb begin
    next_lsd = lsd_step;
    next_msd = lsd_roll ? msd_step : cnt_msd;
    if (terminal) begin
`ifdef BCD_CNT_DOWN_EN
      if (dir_down) begin
        next_lsd = TERM_LSD;
        next_msd = TERM_MSD;
      end else begin
        next_lsd = MIN_DIGIT;
        next_msd = MIN_DIGIT;
      end
`else
      next_lsd = MIN_DIGIT;
      next_msd = MIN_DIGIT;
`endif
    end
  end

  assign load_value = ({4'd0, cnt_load_msd} * 8'd10) + {4'd0, cnt_load_lsd};
  assign load_ok    = (cnt_load_lsd <= BCD_MAX_DIGIT) &&
                      (cnt_load_msd <= BCD_MAX_DIGIT) &&
                      (load_value < MOD_W);

  always_ff @(posedge cnt_clock or posedge reset) begin
    if (reset) begin
      cnt_lsd      <= MIN_DIGIT;
      cnt_msd      <= MIN_DIGIT;
      cnt_load_err <= 1'b0;
    end else if (cnt_load) begin
      if (load_ok) begin
        cnt_lsd      <= cnt_load_lsd;
        cnt_msd      <= cnt_load_msd;
        cnt_load_err <= 1'b0;
      end else begin
        cnt_load_err <= 1'b1;
      end
    end else if (cnt_en) begin
      cnt_lsd <= next_lsd;
      cnt_msd <= next_msd;
    end
  end

  assign cnt_carry = cnt_en & ~cnt_load & terminal;

endmodule

`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
// ============================================================================
// tb_bcd_mod_counter : three counters (mod 60, 24, 100) on shared stimulus,
// checked against an integer-arithmetic reference model.
// ============================================================================
`default_nettype none

module tb_bcd_mod_counter;

  typedef struct {
    bit         e;
    bit         l;
    logic [3:0] ll;
    logic [3:0] lm;
    bit         d;
    int         want_v;
    bit         want_c;
    bit         want_err;
  } row_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       dn  = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] llsd = 4'd0;
  logic [3:0] lmsd = 4'd0;

  logic [3:0] lsd_o [3];
  logic [3:0] msd_o [3];
  logic       carry_o [3];
  logic       err_o [3];

  int   mods [3] = '{60, 24, 100};
  int   ev   [3];
  bit   eerr [3];
  bit   ec   [3];
  logic oc   [3];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MODULUS(60)) u_m60 (
    .cnt_clock(clk), .reset(rst), .cnt_en(en), .cnt_down(dn), .cnt_load(ld),
    .cnt_load_lsd(llsd), .cnt_load_msd(lmsd), .cnt_lsd(lsd_o[0]),
    .cnt_msd(msd_o[0]), .cnt_carry(carry_o[0]), .cnt_load_err(err_o[0]));

  bcd_mod_counter #(.MODULUS(24)) u_m24 (
    .cnt_clock(clk), .reset(rst), .cnt_en(en), .cnt_down(dn), .cnt_load(ld),
    .cnt_load_lsd(llsd), .cnt_load_msd(lmsd), .cnt_lsd(lsd_o[1]),
    .cnt_msd(msd_o[1]), .cnt_carry(carry_o[1]), .cnt_load_err(err_o[1]));

  bcd_mod_counter #(.MODULUS(100)) u_m100 (
    .cnt_clock(clk), .reset(rst), .cnt_en(en), .cnt_down(dn), .cnt_load(ld),
    .cnt_load_lsd(llsd), .cnt_load_msd(lmsd), .cnt_lsd(lsd_o[2]),
    .cnt_msd(msd_o[2]), .cnt_carry(carry_o[2]), .cnt_load_err(err_o[2]));

  function automatic bit dir_down(bit d);
`ifdef BCD_CNT_DOWN_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  function automatic bit load_ok(int m, logic [3:0] l, logic [3:0] h);
    return (h <= 9) && (l <= 9) && ((int'(h) * 10 + int'(l)) < m);
  endfunction

  function automatic logic [7:0] as_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle from posedge+1, sample carry mid-cycle, advance the model.
  task automatic tick(bit e, bit l, logic [3:0] ll, logic [3:0] lm, bit d);
    en = e; ld = l; llsd = ll; lmsd = lm; dn = d;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      oc[i] = carry_o[i];
      ec[i] = e && !l && (dir_down(d) ? (ev[i] == 0) : (ev[i] == mods[i] - 1));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (l) begin
        if (load_ok(mods[i], ll, lm)) begin
          ev[i] = int'(lm) * 10 + int'(ll);
          eerr[i] = 1'b0;
        end else begin
          eerr[i] = 1'b1;
        end
      end else if (e) begin
        ev[i] = dir_down(d) ? (ev[i] + mods[i] - 1) % mods[i] : (ev[i] + 1) % mods[i];
      end
    end
    en = 1'b0; ld = 1'b0;
  endtask

  task automatic run_table(string tag, int tgt, row_t rows [$]);
    foreach (rows[k]) begin
      tick(rows[k].e, rows[k].l, rows[k].ll, rows[k].lm, rows[k].d);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({msd_o[i], lsd_o[i]} !== as_bcd(ev[i])) begin
          errors++;
          $display("FAIL %s step%0d m%0d value: got %h%h want %0d", tag, k, mods[i], msd_o[i], lsd_o[i], ev[i]);
        end
        checks++;
        if (oc[i] !== ec[i]) begin
          errors++;
          $display("FAIL %s step%0d m%0d carry: got %b want %b", tag, k, mods[i], oc[i], ec[i]);
        end
        checks++;
        if (err_o[i] !== eerr[i]) begin
          errors++;
          $display("FAIL %s step%0d m%0d load_err: got %b want %b", tag, k, mods[i], err_o[i], eerr[i]);
        end
      end
      checks++;
      if ({msd_o[tgt], lsd_o[tgt], oc[tgt], err_o[tgt]} !==
          {as_bcd(rows[k].want_v), rows[k].want_c, rows[k].want_err}) begin
        errors++;
        $display("FAIL %s step%0d directed m%0d: got %h%h c=%b e=%b want %0d c=%b e=%b",
                 tag, k, mods[tgt], msd_o[tgt], lsd_o[tgt], oc[tgt], err_o[tgt],
                 rows[k].want_v, rows[k].want_c, rows[k].want_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dn = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({msd_o[i], lsd_o[i], carry_o[i], err_o[i]} !== 10'd0) begin
        errors++;
        $display("FAIL reset_state m%0d: got %h%h c=%b e=%b want 00 c=0 e=0", mods[i], msd_o[i], lsd_o[i], carry_o[i], err_o[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    tick(1'b0, 1'b1, 4'd7, 4'd3, 1'b0);
    checks++;
    if ({msd_o[0], lsd_o[0], err_o[1]} !== {8'h37, 1'b1}) begin
      errors++;
      $display("FAIL reset_preload: got m60=%h%h m24err=%b want 37 1", msd_o[0], lsd_o[0], err_o[1]);
    end
    #2;
    rst = 1'b1; en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({msd_o[i], lsd_o[i], carry_o[i], err_o[i]} !== 10'd0) begin
        errors++;
        $display("FAIL reset_async m%0d: got %h%h c=%b e=%b want 00 c=0 e=0", mods[i], msd_o[i], lsd_o[i], carry_o[i], err_o[i]);
      end
      ev[i] = 0; eerr[i] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      checks++;
      if ({msd_o[0], lsd_o[0]} !== as_bcd(k) || {msd_o[1], lsd_o[1]} !== as_bcd(ev[1])) begin
        errors++;
        $display("FAIL reset_restart %0d: got m60=%h%h m24=%h%h want %0d", k, msd_o[0], lsd_o[0], msd_o[1], lsd_o[1], k);
      end
    end
  endtask

  task automatic test_wrap60();
    row_t r [$] = '{
      '{0, 1, 4'd8, 4'd5, 0, 58, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0, 59, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0,  0, 1, 0},
      '{0, 0, 4'd0, 4'd0, 0,  0, 0, 0},
      '{0, 0, 4'd0, 4'd0, 0,  0, 0, 0}};
    run_table("wrap60", 0, r);
  endtask

  task automatic test_mod24();
    row_t r [$] = '{
      '{0, 1, 4'd9, 4'd0, 0,  9, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0, 10, 0, 0},
      '{0, 1, 4'd3, 4'd2, 0, 23, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0,  0, 1, 0},
      '{0, 0, 4'd0, 4'd0, 0,  0, 0, 0},
      '{0, 1, 4'd4, 4'd2, 0,  0, 0, 1},
      '{1, 0, 4'd0, 4'd0, 0,  1, 0, 1},
      '{0, 1, 4'd2, 4'd1, 0, 12, 0, 0}};
    run_table("mod24", 1, r);
  endtask

  task automatic test_bad_bcd();
    row_t r [$] = '{
      '{0, 1, 4'd3, 4'd6, 0, 63, 0, 0},
      '{0, 1, 4'hA, 4'd6, 0, 63, 0, 1},
      '{1, 0, 4'd0, 4'd0, 0, 64, 0, 1},
      '{0, 1, 4'd9, 4'd9, 0, 99, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0,  0, 1, 0}};
    run_table("bad_bcd", 2, r);
  endtask

  task automatic test_down();
`ifdef BCD_CNT_DOWN_EN
    row_t r [$] = '{
      '{0, 1, 4'd0, 4'd0, 1,  0, 0, 0},
      '{1, 0, 4'd0, 4'd0, 1, 59, 1, 0},
      '{1, 0, 4'd0, 4'd0, 1, 58, 0, 0},
      '{0, 1, 4'd0, 4'd5, 1, 50, 0, 0},
      '{1, 0, 4'd0, 4'd0, 1, 49, 0, 0},
      '{1, 0, 4'd0, 4'd0, 0, 50, 0, 0}};
`else
    row_t r [$] = '{
      '{0, 1, 4'd0, 4'd0, 1,  0, 0, 0},
      '{1, 0, 4'd0, 4'd0, 1,  1, 0, 0},
      '{1, 0, 4'd0, 4'd0, 1,  2, 0, 0},
      '{0, 1, 4'd9, 4'd5, 1, 59, 0, 0},
      '{1, 0, 4'd0, 4'd0, 1,  0, 1, 0}};
`endif
    run_table("down", 0, r);
  endtask

  task automatic test_load_enable();
    row_t r [$] = '{
      '{0, 1, 4'd9, 4'd5, 0, 59, 0, 0},
      '{1, 1, 4'd0, 4'd3, 0, 30, 0, 0}};
    run_table("load_enable", 0, r);
  endtask

  task automatic test_random();
    row_t r [$];
    for (int k = 0; k < 400; k++) begin
      row_t x;
      x.e  = ($urandom_range(0, 3) != 0);
      x.l  = ($urandom_range(0, 9) == 0);
      x.ll = 4'($urandom_range(0, 15));
      x.lm = 4'($urandom_range(0, 11));
      x.d  = ($urandom_range(0, 2) == 0);
      // Directed column mirrors the model for the mod-100 stage only.
      if (x.l) begin
        if (load_ok(100, x.ll, x.lm)) begin
          x.want_v = int'(x.lm) * 10 + int'(x.ll); x.want_err = 1'b0;
        end else begin
          x.want_v = (k == 0) ? ev[2] : r[k-1].want_v;
          x.want_err = 1'b1;
        end
        x.want_c = 1'b0;
      end else begin
        int prev = (k == 0) ? ev[2] : r[k-1].want_v;
        x.want_err = (k == 0) ? eerr[2] : r[k-1].want_err;
        x.want_c = x.e && (dir_down(x.d) ? prev == 0 : prev == 99);
        x.want_v = !x.e ? prev : dir_down(x.d) ? (prev + 99) % 100 : (prev + 1) % 100;
      end
      r.push_back(x);
    end
    run_table("random", 2, r);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ev[i] = 0; eerr[i] = 1'b0;
    end
    test_reset();
    test_wrap60();
    test_mod24();
    test_bad_bcd();
    test_down();
    test_load_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
